led_blink_arbiter: RTL
======================

# led_blink_arbiter

Shares the board's single status LED among up to 8 requesters. Each requester asks for the LED with a display mode (off, solid, slow blink, fast blink). The block grants the LED round-robin with a fixed time slot and generates the blink waveform for the current owner. It sits between the application logic and the LED pin, on the same `sys_clk` domain as the LED driver.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `TICK_DIV`, default 25_000_000: `sys_clk` cycles per blink tick; must be ≥ 2.
- `HOLD_TICKS`, default 4: ticks in one grant slot; must be ≥ 1.

Ports:
- `sys_clk` in 1: the block's only clock; everything is registered on its rising edge.
- `sys_rst` in 1: reset, synchronous, active-high.
- `req` in `NUM_REQ`: level request per requester.
- `mode` in `2*NUM_REQ`: `mode[2i+1:2i]` is requester i's mode. 00 = OFF, 01 = ON, 10 = SLOW, 11 = FAST.
- `grant` out `NUM_REQ`: one-hot current owner, or all zero.
- `led` out 1: LED drive, active-high.
- `busy` out 1: high whenever `grant` is non-zero.

## Operation
- States: IDLE and OWN.
- Reset:
  - State goes to IDLE; `grant`, `led` and `busy` go to 0.
  - Prescaler and slot counter go to 0.
  - The round-robin pointer is set so requester 0 has first priority.
- IDLE:
  - When any `req` bit is set, move to OWN and grant the first requester at or after the pointer, wrapping.
- Every new grant, including a hand-over, does all of the following:
  - prescaler = 0, tick count = 0, blink phase = 1;
  - pointer = granted index + 1, mod `NUM_REQ`.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only in OWN.
  - A tick is the cycle in which the prescaler equals `TICK_DIV`-1; the prescaler wraps to 0 on that cycle.
- Blink phase:
  - FAST: phase toggles on every tick.
  - SLOW: phase toggles on every second tick.
- `led` output by mode:
  - OFF: 0.
  - ON: 1.
  - SLOW or FAST: equals phase.
- Mode changes by the current owner take effect on the next edge; phase is not reset.
- Slot end: occurs on the tick that completes `HOLD_TICKS` ticks.
  - If another requester is asserting `req`, hand over to the next one round-robin on that same edge.
  - If no other requester is asserting, keep the grant and restart the slot count.
- Owner drops `req`: on the next edge, hand over to the next requester round-robin. If there is none, go to IDLE; `grant` = 0 and `led` = 0.
- Owner drop and slot end on the same edge: exactly one transition, with the drop rule applied. No intermediate grant value, no gap cycle.
- Reset while in OWN: the reset values above apply on the next edge, overriding everything else.
- Widths:
  - Prescaler width is `$clog2(TICK_DIV)`.
  - Slot counter width is `$clog2(HOLD_TICKS+1)`.
  - Counters never exceed their terminal value.

## Timing
- Grant latency: `grant`, `busy` and `led` update on the first rising edge where `req` is sampled high. That is 1 cycle, and all three change on the same edge.
- First blink half-period after a grant: exactly `TICK_DIV` cycles (FAST) or `2*TICK_DIV` cycles (SLOW), with `led`=1.
- Slot length: exactly `HOLD_TICKS*TICK_DIV` cycles of `grant` high.
- Release latency: 1 cycle from `req` sampled low to `grant` changing.
- All outputs are registered. `grant` is never multi-hot in any cycle.

## Structure
- Shared package `led_pkg` contains:
  - the mode encoding constants `LED_OFF`, `LED_ON`, `LED_SLOW`, `LED_FAST`;
  - the state enum for IDLE and OWN.
- Sub-module `led_rr_pick` is combinational. Inputs: the request vector, the pointer, and an exclude mask. Outputs: a one-hot pick and a found flag. It is used for both IDLE arbitration and hand-over.
- The top level holds the FSM, prescaler, slot counter, phase register and output registers.

## Test plan
Bench parameters: `TICK_DIV`=4, `HOLD_TICKS`=2, `NUM_REQ`=4.
- Reset: hold `sys_rst`=1 for 5 cycles with `req`=4'b1111, then release.
  - During reset: `grant`=0, `led`=0, `busy`=0.
  - After release: `grant`=4'b0001 one edge later.
- FAST: `req`=4'b0010 with mode FAST.
  - `grant`=4'b0010 after 1 cycle.
  - `led` is high 4 cycles, low 4 cycles, repeating.
- SLOW on requester 1: `led` is high 8 cycles, low 8 cycles, repeating.
- Rotation: `req`=4'b1011, all requesters ON.
  - `grant` sequence is 0001, 0010, 1000, 0001, each held exactly 8 cycles.
  - `led` stays 1 throughout.
- Drop:
  - Start with owner 0 and `req`=4'b0101; drop `req[0]` → `grant`=4'b0100 next edge.
  - Then drop all requests → `grant`=0, `led`=0, `busy`=0 next edge.
- Collision: owner drops `req` on the slot-end tick while 2 others are requesting.
  - Exactly one hand-over occurs, to the round-robin-next requester.
  - No all-zero cycle and no multi-hot `grant`.
- Reset mid-slot, at prescaler=2 → all outputs are 0 on the next edge.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the status-LED arbiter: mode encodings, FSM state
// type and the helper that turns a mode plus blink phase into an LED level.
package led_pkg;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_ON   = 2'b01;
    localparam logic [1:0] LED_SLOW = 2'b10;
    localparam logic [1:0] LED_FAST = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } led_state_e;

    // LED level for a given display mode; blinking modes follow the phase.
    function automatic logic led_level(input logic [1:0] m, input logic phase);
        logic lvl;
        case (m)
            LED_OFF:  lvl = 1'b0;
            LED_ON:   lvl = 1'b1;
            LED_SLOW: lvl = phase;
            LED_FAST: lvl = phase;
            default:  lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/led_blink_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// the pointer (wrapping) that is not excluded, as a one-hot vector.
module led_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] excl,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    localparam logic [PTR_W:0] LIM = (PTR_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] masked_s;
    logic [PTR_W:0]     sum_s;
    logic [PTR_W-1:0]   idx_s;
    logic               hit_s;

    // Scan candidates starting at the pointer; the first hit wins.
    always_comb begin
        masked_s = req & ~excl;
        pick     = '0;
        found    = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s       = {1'b0, ptr} + (PTR_W+1)'(i);
            idx_s       = (sum_s >= LIM) ? PTR_W'(sum_s - LIM) : sum_s[PTR_W-1:0];
            hit_s       = masked_s[idx_s] & ~found;
            pick[idx_s] = pick[idx_s] | hit_s;
            found       = found | hit_s;
        end
    end

endmodule

// File: rtl/led_blink_arbiter.sv
// Status-LED arbiter: grants the single LED round-robin among requesters in
// fixed time slots and generates the blink waveform for the current owner.
module led_blink_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TICK_DIV   = 25_000_000,
    parameter int HOLD_TICKS = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] mode,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 led,
    output logic                 busy
);
    import led_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int SLT_W = $clog2(HOLD_TICKS + 1);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [SLT_W-1:0] SLT_LAST = SLT_W'(HOLD_TICKS - 1);
    localparam logic [SLT_W-1:0] SLT_ONE  = SLT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Index of the set bit in a one-hot vector.
    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res = res | (PTR_W'(i) & {PTR_W{oh[i]}});
        end
        return res;
    endfunction

    // Mode field of the requester selected by a one-hot vector.
    function automatic logic [1:0] oh_mode(input logic [NUM_REQ-1:0] oh,
                                           input logic [2*NUM_REQ-1:0] modes);
        logic [1:0] res;
        res = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            res = res | (modes[2*i +: 2] & {2{oh[i]}});
        end
        return res;
    endfunction

    led_state_e         state_r, state_nxt_s;
    logic [PTR_W-1:0]   ptr_r, ptr_nxt_s;
    logic [PRE_W-1:0]   presc_r, presc_nxt_s;
    logic [SLT_W-1:0]   slot_r, slot_nxt_s;
    logic               sub_r, sub_nxt_s;
    logic               phase_r, phase_nxt_s;
    logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
    logic               led_r, led_nxt_s;
    logic               busy_r, busy_nxt_s;

    logic [NUM_REQ-1:0] excl_s, pick_s;
    logic               found_s, load_s, owner_req_s, tick_s, slot_end_s, toggle_s;
    logic [1:0]         cur_mode_s, new_mode_s;
    logic [PTR_W-1:0]   pick_idx_s;

    // While owning, the current owner is excluded so hand-over moves on.
    always_comb begin
        if (state_r == ST_OWN) begin
            excl_s = grant_r;
        end else begin
            excl_s = '0;
        end
    end

    led_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .excl  (excl_s),
        .pick  (pick_s),
        .found (found_s)
    );

    // Status decode: owner still asking, prescaler tick, slot completion.
    always_comb begin
        owner_req_s = |(req & grant_r);
        tick_s      = (state_r == ST_OWN) && (presc_r == PRE_MAX);
        slot_end_s  = tick_s && (slot_r == SLT_LAST);
        cur_mode_s  = oh_mode(grant_r, mode);
        new_mode_s  = oh_mode(pick_s, mode);
        pick_idx_s  = oh_to_idx(pick_s);
        toggle_s    = (cur_mode_s == LED_FAST) || ((cur_mode_s == LED_SLOW) && sub_r);
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a drop by the owner takes precedence over slot end.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ST_OWN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!owner_req_s) begin
                    if (found_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (slot_end_s && found_s) begin
                    load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_OWN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of grant, counters, phase and LED for the coming edge.
    always_comb begin
        grant_nxt_s = grant_r;
        ptr_nxt_s   = ptr_r;
        presc_nxt_s = presc_r;
        slot_nxt_s  = slot_r;
        sub_nxt_s   = sub_r;
        phase_nxt_s = phase_r;
        led_nxt_s   = led_r;
        if (load_s) begin
            grant_nxt_s = pick_s;
            ptr_nxt_s   = (pick_idx_s == PTR_LAST) ? '0 : pick_idx_s + PTR_ONE;
            presc_nxt_s = '0;
            slot_nxt_s  = '0;
            sub_nxt_s   = 1'b0;
            phase_nxt_s = 1'b1;
            led_nxt_s   = led_level(new_mode_s, 1'b1);
        end else if (state_nxt_s == ST_IDLE) begin
            grant_nxt_s = '0;
            presc_nxt_s = '0;
            slot_nxt_s  = '0;
            sub_nxt_s   = 1'b0;
            phase_nxt_s = 1'b0;
            led_nxt_s   = 1'b0;
        end else if (tick_s) begin
            presc_nxt_s = '0;
            slot_nxt_s  = slot_end_s ? '0 : slot_r + SLT_ONE;
            sub_nxt_s   = ~sub_r;
            phase_nxt_s = phase_r ^ toggle_s;
            led_nxt_s   = led_level(cur_mode_s, phase_r ^ toggle_s);
        end else begin
            presc_nxt_s = presc_r + PRE_ONE;
            led_nxt_s   = led_level(cur_mode_s, phase_r);
        end
        busy_nxt_s = |grant_nxt_s;
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ptr_r   <= '0;
            presc_r <= '0;
            slot_r  <= '0;
            sub_r   <= 1'b0;
            phase_r <= 1'b0;
            grant_r <= '0;
            led_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ptr_r   <= ptr_nxt_s;
            presc_r <= presc_nxt_s;
            slot_r  <= slot_nxt_s;
            sub_r   <= sub_nxt_s;
            phase_r <= phase_nxt_s;
            grant_r <= grant_nxt_s;
            led_r   <= led_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign grant = grant_r;
    assign led   = led_r;
    assign busy  = busy_r;

endmodule
